// File: rtl/timer_scheduler.sv
// ---------------------------------------------------------------------------
// timer_scheduler
//
// Several requesters share one countdown timer, such as the 5/7/8-minute
// chamber timers. A round-robin arbiter picks one requester and loads its
// duration into the timer. The block then waits for the timer to expire and
// returns a one-cycle done pulse to that requester. It sits between the
// control FSMs and the single timer instance.
//
// Parameters
//   N_REQ  number of requesters (2..8)
//   SEC_W  seconds width, equal to the timer's counterSeconds width
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low (0 = reset)
//   req          in   level requests, held high until done/aborted
//   req_seconds  in   duration of requester i in bits [i*SEC_W +: SEC_W]
//   grant        out  one-hot owner of the timer, 0 when idle
//   done         out  1-cycle pulse on the owner's bit at timer expiry
//   aborted      out  1-cycle pulse on the owner's bit when it dropped req
//   busy         out  high in every state except IDLE
//   tmr_start    out  timer start strobe, high only in LOAD
//   tmr_seconds  out  timer reload value, latched once per grant
//   tmr_signal   in   timer expiry flag (count == 0)
// ---------------------------------------------------------------------------
module timer_scheduler #(
    parameter int N_REQ = 3,
    parameter int SEC_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SEC_W-1:0] req_seconds,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       aborted,
    output logic                   busy,
    output logic                   tmr_start,
    output logic [SEC_W-1:0]       tmr_seconds,
    input  logic                   tmr_signal
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0] N_WRAP = (PTR_W+1)'(N_REQ);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               abort_now;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   winner;
    logic [N_REQ-1:0]   win_onehot;
    logic [PTR_W:0]     cand;
    logic               found;
    logic [PTR_W:0]     ptr_sum;
    logic [PTR_W-1:0]   ptr_after;

    // Round-robin search. Candidates are visited starting at rr_ptr and
    // wrap past the top index. The first active request wins.
    always_comb begin
        winner     = '0;
        found      = 1'b0;
        cand       = '0;
        win_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= N_WRAP) begin
                cand = cand - N_WRAP;
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
        win_onehot[winner] = 1'b1;
    end

    // After a completed grant, priority moves to the requester just above
    // the owner.
    always_comb begin
        ptr_sum = {1'b0, owner} + (PTR_W+1)'(1);
        if (ptr_sum >= N_WRAP) begin
            ptr_sum = '0;
        end
        ptr_after = ptr_sum[PTR_W-1:0];
    end

    // Next-state logic. In RUN, timer expiry is checked before the
    // owner's request. When both happen in the same cycle, done wins.
    always_comb begin
        state_next = state;
        abort_now  = 1'b0;
        case (state)
            IDLE: if (|req) state_next = LOAD;
            LOAD: state_next = ARM;
            ARM:  state_next = RUN;
            RUN: begin
                if (tmr_signal) begin
                    state_next = DONE;
                end else if (!req[owner]) begin
                    state_next = IDLE;
                    abort_now  = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs and arbitration bookkeeping. The done, aborted and
    // tmr_start pulses each last one cycle because they are cleared by
    // default here. Grant stays on through the DONE cycle and drops as the
    // block returns to IDLE. An abort does not move rr_ptr, so the aborting
    // requester keeps its priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            owner       <= '0;
            grant       <= '0;
            done        <= '0;
            aborted     <= '0;
            busy        <= 1'b0;
            tmr_start   <= 1'b0;
            tmr_seconds <= '0;
        end else begin
            done      <= '0;
            aborted   <= '0;
            tmr_start <= 1'b0;
            busy      <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner       <= winner;
                        grant       <= win_onehot;
                        tmr_seconds <= req_seconds[winner*SEC_W +: SEC_W];
                        tmr_start   <= 1'b1;
                    end
                end
                RUN: begin
                    if (tmr_signal) begin
                        done <= grant;
                    end else if (abort_now) begin
                        aborted <= grant;
                        grant   <= '0;
                    end
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= ptr_after;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_timer_scheduler
//
// Directed and randomized bench for timer_scheduler. The timer is modelled
// as a countdown that decrements by one each clock, so one second is one
// cycle. Expected grants come from a round-robin model. Expected done timing
// comes from the timer's reload/countdown rules.
// ---------------------------------------------------------------------------
module tb_timer_scheduler;

    localparam int N_REQ = 3;
    localparam int SEC_W = 10;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*SEC_W-1:0] req_seconds;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [N_REQ-1:0]       aborted;
    logic                   busy;
    logic                   tmr_start;
    logic [SEC_W-1:0]       tmr_seconds;
    logic                   tmr_signal;

    logic [SEC_W-1:0]       tcount = '0;
    int                     checks = 0;
    int                     errors = 0;
    int                     m_ptr  = 0;

    timer_scheduler #(.N_REQ(N_REQ), .SEC_W(SEC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_seconds (req_seconds),
        .grant       (grant),
        .done        (done),
        .aborted     (aborted),
        .busy        (busy),
        .tmr_start   (tmr_start),
        .tmr_seconds (tmr_seconds),
        .tmr_signal  (tmr_signal)
    );

    always #5 clk = ~clk;

    // Shared countdown timer. It reloads on start and otherwise counts down
    // to zero. Reset does not clear it.
    always @(posedge clk) begin
        if (tmr_start) begin
            tcount <= tmr_seconds;
        end else if (tcount != '0) begin
            tcount <= tcount - 10'd1;
        end
    end
    assign tmr_signal = (tcount == '0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advances the clock until a done or aborted pulse appears. It reports
    // the number of cycles taken (-1 on timeout), the number of tmr_start
    // pulses seen, and the tmr_signal value in the cycle before the pulse.
    task automatic wait_event(input int limit, output int n, output int starts, output logic sig_before);
        logic prev;
        n          = 0;
        starts     = 0;
        sig_before = 1'b0;
        prev       = tmr_signal;
        for (int i = 0; i < limit; i++) begin
            tick;
            n++;
            starts += int'(tmr_start);
            if ((done | aborted) != '0) begin
                sig_before = prev;
                return;
            end
            prev = tmr_signal;
        end
        n = -1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        req   = '0;
        tick;
        tick;
        reset = 1'b1;
        m_ptr = 0;
    endtask

    // Round-robin reference: the first requester at or after ptr, with wrap.
    function automatic int model_winner(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // Cycles from the LOAD cycle to the done pulse for duration d, given a
    // timer reloaded at the end of LOAD and a one-cycle ARM wait.
    function automatic int run_cycles(input int d);
        return 2 + ((d == 0) ? 1 : d);
    endfunction

    initial begin
        int               n;
        int               st;
        logic             sb;
        int               w;
        int               d;
        logic [N_REQ-1:0] bit_w;

        reset       = 1'b0;
        req         = '0;
        req_seconds = '0;
        tick;
        tick;
        check_output("rst_grant",   32'(grant),       0);
        check_output("rst_done",    32'(done),        0);
        check_output("rst_aborted", 32'(aborted),     0);
        check_output("rst_busy",    32'(busy),        0);
        check_output("rst_start",   32'(tmr_start),   0);
        check_output("rst_seconds", 32'(tmr_seconds), 0);
        reset = 1'b1;

        // Single request with a 3-second duration
        req_seconds = {10'd7, 10'd5, 10'd3};
        req = 3'b001;
        tick;
        check_output("t1_grant",   32'(grant),       1);
        check_output("t1_start",   32'(tmr_start),   1);
        check_output("t1_seconds", 32'(tmr_seconds), 3);
        check_output("t1_busy",    32'(busy),        1);
        wait_event(50, n, st, sb);
        check_output("t1_cycles",  32'(n),           32'(run_cycles(3)));
        check_output("t1_done",    32'(done),        1);
        check_output("t1_aborted", 32'(aborted),     0);
        check_output("t1_starts",  32'(st),          0);
        check_output("t1_sigprev", 32'(sb),          1);
        req = '0;
        tick;
        check_output("t1_idle_busy",  32'(busy),  0);
        check_output("t1_idle_grant", 32'(grant), 0);
        check_output("t1_idle_done",  32'(done),  0);

        // Round-robin with every request held
        do_reset;
        req_seconds = {10'd1, 10'd1, 10'd1};
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_output("t2_grant", 32'(grant), 32'(3'b001 << (i % 3)));
            wait_event(20, n, st, sb);
            check_output("t2_cycles", 32'(n),    32'(run_cycles(1)));
            check_output("t2_done",   32'(done), 32'(3'b001 << (i % 3)));
            check_output("t2_starts", 32'(st),   0);
            if (i == 3) req = '0;
            tick;
            check_output("t2_idle_busy", 32'(busy), 0);
            check_output("t2_idle_done", 32'(done), 0);
        end

        // Abort by requester 0; pending requester 1 goes next
        do_reset;
        req_seconds = {10'd4, 10'd2, 10'd300};
        req = 3'b001;
        tick;
        check_output("t3_grant0", 32'(grant), 1);
        tick;
        tick;
        req = 3'b011;
        tick;
        tick;
        check_output("t3_hold_grant", 32'(grant), 1);
        check_output("t3_hold_done",  32'(done | aborted), 0);
        req = 3'b010;
        wait_event(10, n, st, sb);
        check_output("t3_ab_cycles", 32'(n),       1);
        check_output("t3_aborted",   32'(aborted), 1);
        check_output("t3_ab_done",   32'(done),    0);
        check_output("t3_ab_grant",  32'(grant),   0);
        check_output("t3_ab_busy",   32'(busy),    0);
        tick;
        check_output("t3_grant1",   32'(grant),       2);
        check_output("t3_seconds1", 32'(tmr_seconds), 2);
        wait_event(20, n, st, sb);
        check_output("t3_done1",    32'(done), 2);
        check_output("t3_cycles1",  32'(n),    32'(run_cycles(2)));

        // Abort must not advance the pointer, so requester 2 keeps priority
        req = 3'b100;
        tick;
        tick;
        check_output("t3b_grant2", 32'(grant), 4);
        tick;
        tick;
        req = 3'b000;
        wait_event(10, n, st, sb);
        check_output("t3b_aborted", 32'(aborted), 4);
        req = 3'b101;
        tick;
        check_output("t3b_keep_priority", 32'(grant), 4);
        wait_event(20, n, st, sb);
        check_output("t3b_done",   32'(done), 4);
        check_output("t3b_cycles", 32'(n),    32'(run_cycles(4)));

        // Request drops in the same cycle the timer expires
        req = 3'b001;
        req_seconds[9:0] = 10'd2;
        tick;
        tick;
        check_output("t4_grant", 32'(grant), 1);
        tick;
        check_output("t4_arm_signal", 32'(tmr_signal), 0);
        for (int i = 0; i < 10 && !tmr_signal; i++) tick;
        check_output("t4_signal", 32'(tmr_signal), 1);
        req = 3'b000;
        tick;
        check_output("t4_done",    32'(done),    1);
        check_output("t4_aborted", 32'(aborted), 0);
        tick;
        check_output("t4_idle_busy", 32'(busy), 0);

        // Zero duration: done exactly 4 cycles after the IDLE grant cycle
        req = 3'b100;
        req_seconds[29:20] = 10'd0;
        wait_event(20, n, st, sb);
        check_output("t5_cycles", 32'(n),    4);
        check_output("t5_done",   32'(done), 4);
        check_output("t5_starts", 32'(st),   1);
        req = '0;
        tick;

        // Asynchronous reset in the middle of RUN
        req = 3'b001;
        req_seconds[9:0] = 10'd50;
        tick;
        tick;
        tick;
        tick;
        check_output("t6_busy_run", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check_output("t6_grant",   32'(grant),       0);
        check_output("t6_busy",    32'(busy),        0);
        check_output("t6_start",   32'(tmr_start),   0);
        check_output("t6_pulses",  32'(done | aborted), 0);
        check_output("t6_seconds", 32'(tmr_seconds), 0);
        tick;
        check_output("t6_no_pulse", 32'(done | aborted), 0);
        req = 3'b010;
        reset = 1'b1;
        tick;
        check_output("t6_grant_after", 32'(grant), 2);
        wait_event(20, n, st, sb);
        check_output("t6_done", 32'(done), 2);
        req = '0;
        tick;

        // Randomized traffic checked against the round-robin model
        do_reset;
        for (int it = 0; it < 40; it++) begin
            req = 3'($urandom_range(0, 7));
            for (int i = 0; i < N_REQ; i++) begin
                req_seconds[i*SEC_W +: SEC_W] = 10'($urandom_range(0, 6));
            end
            w = model_winner(req, m_ptr);
            if (w < 0) begin
                tick;
                check_output("rnd_idle_busy",  32'(busy),  0);
                check_output("rnd_idle_grant", 32'(grant), 0);
                continue;
            end
            d = int'(req_seconds[w*SEC_W +: SEC_W]);
            bit_w = 3'b001 << w;
            tick;
            check_output("rnd_grant",   32'(grant),       32'(bit_w));
            check_output("rnd_seconds", 32'(tmr_seconds), 32'(d));
            check_output("rnd_start",   32'(tmr_start),   1);
            req_seconds = 30'($urandom);
            req = 3'($urandom_range(0, 7)) | bit_w;
            if (d >= 3 && $urandom_range(0, 3) == 0) begin
                tick;
                tick;
                req = req & ~bit_w;
                wait_event(10, n, st, sb);
                check_output("rnd_ab_cycles", 32'(n),       1);
                check_output("rnd_aborted",   32'(aborted), 32'(bit_w));
                check_output("rnd_ab_done",   32'(done),    0);
                check_output("rnd_ab_busy",   32'(busy),    0);
            end else begin
                wait_event(40, n, st, sb);
                check_output("rnd_cycles",  32'(n),       32'(run_cycles(d)));
                check_output("rnd_done",    32'(done),    32'(bit_w));
                check_output("rnd_aborted", 32'(aborted), 0);
                m_ptr = (w + 1) % N_REQ;
                tick;
                check_output("rnd_after_busy",  32'(busy),  0);
                check_output("rnd_after_grant", 32'(grant), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
